// File: rtl/seg_scan_pkg.sv
// Shared types and segment constants for the seven-segment scan controller.
// Patterns are ordered {g,f,e,d,c,b,a}, active-high.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Index n holds the pattern for BCD digit n.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to seven-segment decoder; codes 10..15 decode to blank.
module seg_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9)
            seg = SEG_DIGITS[bcd];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered BCD value.
// Optional macro LEADING_ZERO_BLANK_EN suppresses zeros above the top non-zero digit.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV          = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int CNT_W        = $clog2(DIV)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic                      frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                        state, nxt_state;
    logic [IDX_W-1:0]                   idx, nxt_idx;
    logic [CNT_W-1:0]                   cnt, nxt_cnt;
    logic [NUM_DIGITS-1:0][3:0]         pending, shadow;
    logic [NUM_DIGITS-1:0][6:0]         dec_seg, lit_seg;
    logic [NUM_DIGITS-1:0]              keep;
    logic                               wrap, frame_start;
    logic [6:0]                         seg_d;
    logic [NUM_DIGITS-1:0]              dig_d;
    logic                               frame_d;

    assign wrap        = (state == SHOW) && (cnt == SHOW_LAST) && (idx == IDX_LAST);
    assign frame_start = enable && ((state == IDLE) || wrap);

    // Every shadow digit is decoded in parallel; the scan index just selects one.
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            seg_decode u_dec (
                .bcd (shadow[g]),
                .seg (dec_seg[g])
            );
            assign lit_seg[g] = keep[g] ? dec_seg[g] : SEG_BLANK;
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz;

    // A digit stays lit if it or any higher digit is non-zero; digit 0 always stays lit.
    always_comb begin
        seen_nz = 1'b0;
        keep    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (shadow[i] != 4'd0);
            keep[i] = seen_nz | (i == 0);
        end
    end
`else
    assign keep = '1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cnt   <= nxt_cnt;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + CNT_W'(1);
        if (!enable) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = BLANK;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        nxt_state = SHOW;
                        nxt_cnt   = '0;
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        nxt_state = BLANK;
                        nxt_cnt   = '0;
                        nxt_idx   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs follow the next state so they change on the same edge as the FSM.
    // Shadow never changes on entry to SHOW, so the current decode is the right one.
    always_comb begin
        seg_d   = SEG_BLANK;
        dig_d   = '0;
        frame_d = enable && wrap;
        if (nxt_state == SHOW) begin
            seg_d = lit_seg[nxt_idx];
            dig_d = NUM_DIGITS'(1) << nxt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_out    <= SEG_BLANK;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= seg_d;
            dig_en     <= dig_d;
            frame_done <= frame_d;
        end
    end

    // A load landing on a frame-start edge goes straight into shadow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            shadow  <= '0;
        end else begin
            if (load)
                pending <= digits_in;
            if (frame_start)
                shadow <= load ? digits_in : pending;
        end
    end

endmodule
